// File: rtl/cdc_pkg.sv
// Shared types and constants for the CDC handshake receiver and its helpers.
package cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cdc_rx_state_e;

  localparam int unsigned CDC_RX_FIFO_DP = 2;

endpackage

// File: rtl/cdc_sync.sv
// Multi-stage 1-bit synchronizer with synchronous active-high reset (SYNC_DP >= 2).
module cdc_sync #(
  parameter int unsigned SYNC_DP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_DP-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_DP-2:0], d};
  end

  assign q = ff[SYNC_DP-1];

endmodule

// File: rtl/cdc_rx.sv
// Receiving end of the 4-phase CDC handshake, re-issued as local valid/ready.
// Define CDC_RX_FIFO_EN to replace the output register with a 2-entry FIFO.
module cdc_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned SYNC_DP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  logic          vld_s;
  logic          space;
  logic          capture;
  logic          pop;
  cdc_rx_state_e state;

  cdc_sync #(.SYNC_DP(SYNC_DP)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_vld),
    .q   (vld_s)
  );

  assign pop     = o_vld & o_rdy;
  assign capture = (state == IDLE) & vld_s & space;

`ifdef CDC_RX_FIFO_EN
  logic [1:0]    cnt;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          full;
  logic [DW-1:0] mem [CDC_RX_FIFO_DP];

  assign full  = (cnt == 2'(CDC_RX_FIFO_DP));
  assign space = ~full | pop;
  assign o_vld = (cnt != 2'd0);
  assign o_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < CDC_RX_FIFO_DP; i++) mem[i] <= '0;
    end else begin
      if (capture) begin
        mem[wr_ptr] <= i_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, capture} - {1'b0, pop};
    end
  end
`else
  assign space = ~o_vld | o_rdy;

  // Capture takes priority over pop: a same-edge refill keeps o_vld high.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld <= 1'b0;
      o_dat <= '0;
    end else if (capture) begin
      o_vld <= 1'b1;
      o_dat <= i_dat;
    end else if (pop) begin
      o_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i_rdy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (capture) begin
          state <= ACK;
          i_rdy <= 1'b1;
        end
        ACK: if (!vld_s) begin
          state <= IDLE;
          i_rdy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          i_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_rx.sv
// Self-checking bench for cdc_rx (SYNC_DP=2); adapts to the CDC_RX_FIFO_EN build.
module tb_cdc_rx;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  int tests  = 0;
  int failed = 0;

  cdc_rx #(.DW(DW), .SYNC_DP(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        rdy;
    logic [31:0] dat;
    logic        e_irdy;
    logic        e_ovld;
    logic        chk_dat;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irdy(input logic val, input string name);
    int n = 0;
    while (i_rdy !== val && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(i_rdy), 64'(val));
  endtask

  task automatic drain();
    o_rdy = 1'b1;
    repeat (4) tick();
    o_rdy = 1'b0;
  endtask

  // Sender model of the foreign domain: full 4-phase transfer of one word.
  task automatic send4(input logic [31:0] w);
    i_dat = w;
    i_vld = 1'b1;
    wait_irdy(1'b1, "send_ack_rise");
    repeat ($urandom_range(0, 2)) tick();
    i_vld = 1'b0;
    wait_irdy(1'b0, "send_ack_fall");
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    int cyc;
    logic [31:0] exp_next;
    logic        stall_prev;
    logic [31:0] prev_dat;

    rst = 1'b1; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_irdy", 64'(i_rdy), 0);
    chk("reset_ovld", 64'(o_vld), 0);
    chk("reset_odat", 64'(o_dat), 0);

    // Single transfer, o_rdy=1: ack and data after edge 2, ack drops 2 edges after release.
    vt[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[5] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[6] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[7] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      i_vld = vt[i].vld; o_rdy = vt[i].rdy; i_dat = vt[i].dat;
      tick();
      chk($sformatf("vec%0d_irdy", i), 64'(i_rdy), 64'(vt[i].e_irdy));
      chk($sformatf("vec%0d_ovld", i), 64'(o_vld), 64'(vt[i].e_ovld));
      if (vt[i].chk_dat) chk($sformatf("vec%0d_odat", i), 64'(o_dat), 64'(vt[i].e_dat));
    end
    o_rdy = 1'b0;

`ifdef CDC_RX_FIFO_EN
    send4(32'hA);
    send4(32'hB);
    chk("fifo_two_held_vld", 64'(o_vld), 1);
    chk("fifo_head_a", 64'(o_dat), 64'hA);
    i_dat = 32'hC; i_vld = 1'b1;
    repeat (5) tick();
    chk("fifo_full_no_ack", 64'(i_rdy), 0);
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("fifo_pop_cap_ack", 64'(i_rdy), 1);
    chk("fifo_head_b", 64'(o_dat), 64'hB);
    i_vld = 1'b0;
    wait_irdy(1'b0, "fifo_c_release");
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("fifo_head_c", 64'(o_dat), 64'hC);
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("fifo_empty", 64'(o_vld), 0);
`else
    send4(32'hA);
    chk("bp_a_held", 64'(o_dat), 64'hA);
    i_dat = 32'hB; i_vld = 1'b1;
    repeat (5) tick();
    chk("bp_b_no_ack", 64'(i_rdy), 0);
    chk("bp_a_stable", 64'(o_dat), 64'hA);
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("bp_b_ack", 64'(i_rdy), 1);
    chk("bp_ovld_held", 64'(o_vld), 1);
    chk("bp_b_data", 64'(o_dat), 64'hB);
    i_vld = 1'b0;
    wait_irdy(1'b0, "bp_b_release");
    o_rdy = 1'b1;
    tick();
    o_rdy = 1'b0;
    chk("bp_empty", 64'(o_vld), 0);
`endif

    // Stream of 16 words with random local ready; expected sequence is 0..15.
    got = 0; cyc = 0; exp_next = 0; stall_prev = 1'b0; prev_dat = '0;
    fork
      for (int k = 0; k < 16; k++) send4(32'(k));
      while (got < 16 && cyc < 3000) begin
        @(negedge clk);
        o_rdy = 1'($urandom_range(0, 1));
        #1;
        cyc++;
        if (stall_prev) begin
          chk("stream_stall_vld", 64'(o_vld), 1);
          chk("stream_stall_dat", 64'(o_dat), 64'(prev_dat));
        end
        if (o_vld && o_rdy) begin
          chk("stream_word", 64'(o_dat), 64'(exp_next));
          exp_next++;
          got++;
        end
        stall_prev = o_vld && !o_rdy;
        prev_dat   = o_dat;
      end
    join
    chk("stream_count", 64'(got), 16);
    o_rdy = 1'b0;
    repeat (3) tick();
    chk("stream_no_dup", 64'(o_vld), 0);

    // One-cycle request pulse: never acked without a word present.
    i_dat = 32'h5EED; i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_partial", 64'(i_rdy && !o_vld), 0);
    end
    chk("glitch_irdy_idle", 64'(i_rdy), 0);
    chk("glitch_captured", 64'(o_vld), 1);
    chk("glitch_data", 64'(o_dat), 64'h5EED);
    drain();

    // Reset while acked with a word buffered; request still held afterwards.
    i_dat = 32'hA5A5A5A5; i_vld = 1'b1;
    repeat (3) tick();
    chk("rst_pre_irdy", 64'(i_rdy), 1);
    chk("rst_pre_ovld", 64'(o_vld), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_irdy", 64'(i_rdy), 0);
    chk("rst_ovld", 64'(o_vld), 0);
    chk("rst_odat", 64'(o_dat), 0);
    tick();
    chk("rst_edge0_ovld", 64'(o_vld), 0);
    tick();
    chk("rst_edge1_ovld", 64'(o_vld), 0);
    tick();
    chk("rst_recap_ovld", 64'(o_vld), 1);
    chk("rst_recap_irdy", 64'(i_rdy), 1);
    chk("rst_recap_dat", 64'(o_dat), 64'hA5A5A5A5);
    i_vld = 1'b0;
    wait_irdy(1'b0, "rst_release");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
